// File: rtl/track_mixer.sv
// ---------------------------------------------------------------------------
// track_mixer
//
// Time-multiplexed mixer sitting between the per-track tone generators and
// the output channel. On each amplitude-update strobe (wgEn) it snapshots
// every track's sign/magnitude sample and accumulates them sequentially, one
// track per clock, into a two's complement accumulator. The sum is then
// attenuated by 2^SHIFT (truncating toward zero), saturated to 255 and
// converted back to sign/magnitude. Output latency is NUM_INPUTS+1 clocks
// after the strobe edge.
//
// Parameters:
//   NUM_INPUTS  number of tracks mixed (>= 1, NUM_INPUTS+2 < 256)
//   SHIFT       post-sum attenuation, magnitude divided by 2^SHIFT (0..4)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   wgEn          amplitude-update strobe, one clk wide
//   sign          per-track sign, 1 = negative
//   magnitude     per-track unsigned 8-bit magnitude
//   muteMask      per-track mute, 1 = track contributes 0 (MIXER_MUTE_EN only)
//   outSign       mixed sign, 1 = negative (never set for a zero result)
//   outMagnitude  mixed unsigned magnitude
//   done          one-cycle pulse when outSign/outMagnitude update
//   clip          one-cycle pulse with done when saturation occurred
//   overrun       sticky flag, wgEn arrived while a mix was in progress
//
// Optional feature macro: MIXER_MUTE_EN (adds the muteMask input).
// ---------------------------------------------------------------------------
module track_mixer #(
    parameter int NUM_INPUTS = 4,
    parameter int SHIFT      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wgEn,
    input  logic [NUM_INPUTS-1:0]      sign,
    input  logic [NUM_INPUTS-1:0][7:0] magnitude,
`ifdef MIXER_MUTE_EN
    input  logic [NUM_INPUTS-1:0]      muteMask,
`endif
    output logic                       outSign,
    output logic [7:0]                 outMagnitude,
    output logic                       done,
    output logic                       clip,
    output logic                       overrun
);

    localparam int ACC_W = 9 + $clog2(NUM_INPUTS);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [ACC_W-1:0] MAX_MAG  = ACC_W'(255);

    // The whole mix must finish inside one 256-cycle amplitude period.
    if (NUM_INPUTS < 1 || NUM_INPUTS + 2 >= 256) begin : gBadNumInputs
        $error("track_mixer: NUM_INPUTS must be >= 1 and NUM_INPUTS+2 < 256");
    end
    if (SHIFT < 0 || SHIFT > 4) begin : gBadShift
        $error("track_mixer: SHIFT must be in 0..4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2
    } mixState_t;

    mixState_t                  state_q, state_d;
    logic [NUM_INPUTS-1:0]      signSnap_q, signSnap_d;
    logic [NUM_INPUTS-1:0][7:0] magSnap_q, magSnap_d;
`ifdef MIXER_MUTE_EN
    logic [NUM_INPUTS-1:0]      muteSnap_q, muteSnap_d;
`endif
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       outSign_q, outSign_d;
    logic [7:0]                 outMag_q, outMag_d;
    logic                       done_q, done_d;
    logic                       clip_q, clip_d;
    logic                       overrun_q, overrun_d;

    logic [ACC_W-1:0]           trackVal;
    logic [ACC_W-1:0]           absAcc;
    logic [ACC_W-1:0]           scaled;

    // Sign-extended contribution of the snapshot track currently selected by
    // the index. Negating a zero magnitude yields zero, so "-0" adds nothing.
    always_comb begin
        trackVal = {{(ACC_W-8){1'b0}}, magSnap_q[idx_q]};
        if (signSnap_q[idx_q]) begin
            trackVal = -trackVal;
        end
`ifdef MIXER_MUTE_EN
        if (muteSnap_q[idx_q]) begin
            trackVal = '0;
        end
`endif
    end

    // Magnitude of the finished sum, attenuated. Shifting the absolute value
    // (rather than the signed sum) truncates toward zero for both signs.
    always_comb begin
        absAcc = acc_q[ACC_W-1] ? -acc_q : acc_q;
        scaled = absAcc >> SHIFT;
    end

    // Next-state and output logic for the snapshot / accumulate / scale
    // sequence. done and clip default low so they only pulse for one cycle.
    always_comb begin
        state_d    = state_q;
        signSnap_d = signSnap_q;
        magSnap_d  = magSnap_q;
`ifdef MIXER_MUTE_EN
        muteSnap_d = muteSnap_q;
`endif
        acc_d      = acc_q;
        idx_d      = idx_q;
        outSign_d  = outSign_q;
        outMag_d   = outMag_q;
        done_d     = 1'b0;
        clip_d     = 1'b0;
        overrun_d  = overrun_q;

        // A strobe during a mix is dropped but remembered until reset.
        if (wgEn && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (wgEn) begin
                    signSnap_d = sign;
                    magSnap_d  = magnitude;
`ifdef MIXER_MUTE_EN
                    muteSnap_d = muteMask;
`endif
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + trackVal;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                done_d = 1'b1;
                if (scaled > MAX_MAG) begin
                    outMag_d = 8'd255;
                    clip_d   = 1'b1;
                end else begin
                    outMag_d = scaled[7:0];
                end
                // A result that scales to zero is reported as positive.
                outSign_d = acc_q[ACC_W-1] && (scaled != '0);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any mix in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            signSnap_q <= '0;
            magSnap_q  <= '0;
`ifdef MIXER_MUTE_EN
            muteSnap_q <= '0;
`endif
            acc_q      <= '0;
            idx_q      <= '0;
            outSign_q  <= 1'b0;
            outMag_q   <= 8'd0;
            done_q     <= 1'b0;
            clip_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            signSnap_q <= signSnap_d;
            magSnap_q  <= magSnap_d;
`ifdef MIXER_MUTE_EN
            muteSnap_q <= muteSnap_d;
`endif
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            outSign_q  <= outSign_d;
            outMag_q   <= outMag_d;
            done_q     <= done_d;
            clip_q     <= clip_d;
            overrun_q  <= overrun_d;
        end
    end

    assign outSign      = outSign_q;
    assign outMagnitude = outMag_q;
    assign done         = done_q;
    assign clip         = clip_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_track_mixer.sv
// ---------------------------------------------------------------------------
// tb_track_mixer
//
// Directed testbench for track_mixer with the default configuration
// (NUM_INPUTS=4, SHIFT=1). Expected values are worked out by hand for each
// vector. Inputs are driven on the falling edge, outputs sampled on the
// falling edge, so every sample is half a cycle away from the active edge.
// When MIXER_MUTE_EN is defined the muteMask port is connected and exercised.
// ---------------------------------------------------------------------------
module tb_track_mixer;

    logic             clk;
    logic             reset;
    logic             wgEn;
    logic [3:0]       sign;
    logic [3:0][7:0]  magnitude;
`ifdef MIXER_MUTE_EN
    logic [3:0]       muteMask;
`endif
    logic             outSign;
    logic [7:0]       outMagnitude;
    logic             done;
    logic             clip;
    logic             overrun;

    int errCount   = 0;
    int checkCount = 0;
    int latency;
    int doneSeen;

    track_mixer #(
        .NUM_INPUTS (4),
        .SHIFT      (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wgEn         (wgEn),
        .sign         (sign),
        .magnitude    (magnitude),
`ifdef MIXER_MUTE_EN
        .muteMask     (muteMask),
`endif
        .outSign      (outSign),
        .outMagnitude (outMagnitude),
        .done         (done),
        .clip         (clip),
        .overrun      (overrun)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one set of track samples (track 0 first).
    task automatic applyStimulus(input logic [3:0] s, input logic [7:0] m0,
                                 input logic [7:0] m1, input logic [7:0] m2,
                                 input logic [7:0] m3);
        sign      = s;
        magnitude = {m3, m2, m1, m0};
    endtask

    // One-cycle wgEn pulse; returns on the falling edge after E0.
    task automatic startMix();
        @(negedge clk);
        wgEn = 1'b1;
        @(negedge clk);
        wgEn = 1'b0;
    endtask

    // Counts falling edges until done is seen; 0 means it never came.
    task automatic waitDone(output int lat);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        wgEn      = 1'b0;
        sign      = '0;
        magnitude = '0;
`ifdef MIXER_MUTE_EN
        muteMask  = '0;
`endif
        repeat (2) @(negedge clk);

        // Reset state.
        checkOutput("rst_outSign", {31'd0, outSign}, 32'd0);
        checkOutput("rst_outMag", {24'd0, outMagnitude}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_clip", {31'd0, clip}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // +200 +100 +0 +0 -> 300 >> 1 = 150.
        applyStimulus(4'b0000, 8'd200, 8'd100, 8'd0, 8'd0);
        startMix();
        waitDone(latency);
        checkOutput("basic_latency", latency, 32'd5);
        checkOutput("basic_sign", {31'd0, outSign}, 32'd0);
        checkOutput("basic_mag", {24'd0, outMagnitude}, 32'd150);
        checkOutput("basic_clip", {31'd0, clip}, 32'd0);
        @(negedge clk);
        checkOutput("basic_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("basic_hold_mag", {24'd0, outMagnitude}, 32'd150);

        // +100 -100 +0 -0 -> 0, reported as positive zero.
        applyStimulus(4'b1010, 8'd100, 8'd100, 8'd0, 8'd0);
        startMix();
        waitDone(latency);
        checkOutput("zero_latency", latency, 32'd5);
        checkOutput("zero_sign", {31'd0, outSign}, 32'd0);
        checkOutput("zero_mag", {24'd0, outMagnitude}, 32'd0);

        // All -255 -> -1020, scaled 510, saturates to 255 with clip.
        applyStimulus(4'b1111, 8'd255, 8'd255, 8'd255, 8'd255);
        startMix();
        waitDone(latency);
        checkOutput("sat_latency", latency, 32'd5);
        checkOutput("sat_sign", {31'd0, outSign}, 32'd1);
        checkOutput("sat_mag", {24'd0, outMagnitude}, 32'd255);
        checkOutput("sat_clip", {31'd0, clip}, 32'd1);
        @(negedge clk);
        checkOutput("sat_clip_pulse", {31'd0, clip}, 32'd0);

        // -3 0 0 0 -> 3 >> 1 = 1, negative; inputs changed after E0 ignored.
        applyStimulus(4'b0001, 8'd3, 8'd0, 8'd0, 8'd0);
        startMix();
        applyStimulus(4'b0000, 8'd50, 8'd50, 8'd50, 8'd50);
        waitDone(latency);
        checkOutput("trunc_latency", latency, 32'd5);
        checkOutput("trunc_sign", {31'd0, outSign}, 32'd1);
        checkOutput("trunc_mag", {24'd0, outMagnitude}, 32'd1);

        // Second strobe two cycles in: ignored, overrun set.
        // First snapshot +10 +20 +30 +40 -> 100 >> 1 = 50.
        applyStimulus(4'b0000, 8'd10, 8'd20, 8'd30, 8'd40);
        startMix();
        @(negedge clk);
        wgEn = 1'b1;
        applyStimulus(4'b0000, 8'd200, 8'd200, 8'd0, 8'd0);
        @(negedge clk);
        wgEn = 1'b0;
        waitDone(latency);
        checkOutput("ovr_latency", latency, 32'd3);
        checkOutput("ovr_mag", {24'd0, outMagnitude}, 32'd50);
        checkOutput("ovr_sign", {31'd0, outSign}, 32'd0);
        checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("ovr_no_restart", doneSeen, 32'd0);
        checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset two cycles into a mix: outputs cleared, no done.
        applyStimulus(4'b0000, 8'd90, 8'd90, 8'd90, 8'd90);
        startMix();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mag", {24'd0, outMagnitude}, 32'd0);
        checkOutput("midrst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("midrst_no_done", doneSeen, 32'd0);
        checkOutput("midrst_mag_hold", {24'd0, outMagnitude}, 32'd0);

        // Mix after reset: +60 +60 +0 +0 -> 60.
        applyStimulus(4'b0000, 8'd60, 8'd60, 8'd0, 8'd0);
        startMix();
        waitDone(latency);
        checkOutput("post_rst_latency", latency, 32'd5);
        checkOutput("post_rst_mag", {24'd0, outMagnitude}, 32'd60);

        // Back-to-back: strobe in the done cycle is accepted.
        // A: +4 x4 -> 16 >> 1 = 8.  B: -7 +2 -> -5, 5 >> 1 = 2 negative.
        applyStimulus(4'b0000, 8'd4, 8'd4, 8'd4, 8'd4);
        startMix();
        waitDone(latency);
        checkOutput("b2b_a_mag", {24'd0, outMagnitude}, 32'd8);
        wgEn = 1'b1;
        applyStimulus(4'b0001, 8'd7, 8'd2, 8'd0, 8'd0);
        @(negedge clk);
        wgEn = 1'b0;
        waitDone(latency);
        checkOutput("b2b_b_latency", latency, 32'd5);
        checkOutput("b2b_b_sign", {31'd0, outSign}, 32'd1);
        checkOutput("b2b_b_mag", {24'd0, outMagnitude}, 32'd2);
        checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);

`ifdef MIXER_MUTE_EN
        // +80 x4 with tracks 0 and 2 muted -> 160 >> 1 = 80.
        applyStimulus(4'b0000, 8'd80, 8'd80, 8'd80, 8'd80);
        muteMask = 4'b0101;
        startMix();
        muteMask = 4'b0000;
        waitDone(latency);
        checkOutput("mute_latency", latency, 32'd5);
        checkOutput("mute_sign", {31'd0, outSign}, 32'd0);
        checkOutput("mute_mag", {24'd0, outMagnitude}, 32'd80);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/track_mixer.md
Name: track_mixer

Overview:
- Time-multiplexed mixer between the per-track tone generators and the output channels.
- Once per amplitude period, on the `wgEn` strobe, it snapshots every track's sign/magnitude sample and sums them sequentially, one track per clock.
- It then scales, saturates and converts the sum back to sign-magnitude for the output channels.
- Replaces the fixed two-input combinational sum with a parameterised, registered stage.

Parameters:
- NUM_INPUTS, 4, number of tracks mixed (>=1).
- SHIFT, 1, post-sum attenuation: result magnitude divided by 2^SHIFT (0..4).

Ports:
- clk  input  1  system clock (40 MHz).
- reset  input  1  asynchronous, active-high reset.
- wgEn  input  1  amplitude-update strobe, one clk wide, every 256 cycles.
- sign  input  NUM_INPUTS  per-track sign, 1 = negative.
- magnitude  input  NUM_INPUTS x 8  per-track unsigned magnitude.
- outSign  output  1  mixed sign, 1 = negative.
- outMagnitude  output  8  mixed unsigned magnitude.
- done  output  1  one-cycle pulse when outSign/outMagnitude update.
- clip  output  1  one-cycle pulse coincident with done when saturation occurred.
- overrun  output  1  sticky; set when wgEn arrives while not IDLE.

Behaviour:
- Reset (async, active-high): state IDLE; accumulator, snapshot, index cleared; outSign=0, outMagnitude=0, done=0, clip=0, overrun=0. Reset mid-operation aborts the mix with no done pulse.
- Accumulator: two's complement, ACC_W = 9 + $clog2(NUM_INPUTS) bits. Each track is sign-extended: +mag if sign=0, -mag if sign=1. A track with sign=1 and magnitude 0 contributes 0.
- States:
  - IDLE: on a clk edge with wgEn=1, capture all sign/magnitude into a snapshot register, clear accumulator, index=0, go to ACCUM. Call this edge E0.
  - ACCUM: each edge adds snapshot track[index] and increments index. After the edge adding track NUM_INPUTS-1 (edge E_N), go to SCALE.
  - SCALE: compute |acc| >> SHIFT, truncating toward zero (symmetric for both signs). If the result is >255, force 255 and assert clip. outSign = 1 only if acc<0 and the scaled magnitude is nonzero; zero is never negative. Register the outputs at edge E_(N+1) and return to IDLE.
- done (and clip, if applicable) is high for exactly the one cycle following E_(N+1).
- Latency: outputs change NUM_INPUTS+1 clocks after the wgEn edge; 5 clocks for the default. Outputs hold between updates.
- Inputs changing after E0 do not affect the current mix.
- wgEn while in ACCUM or SCALE: ignored (no restart), overrun set to 1, cleared only by reset.
- wgEn in the same cycle as done (state IDLE): accepted normally.
- Synthesis-time check: NUM_INPUTS + 2 < 256, so the mix completes within an amplitude period.

Optional Feature:
- Macro: MIXER_MUTE_EN.
- Defined: adds port `muteMask` (input, NUM_INPUTS). It is captured with the snapshot at E0; a track whose mask bit is 1 contributes 0. Latency is unchanged.
- Undefined: no port; all tracks always contribute.

Test Plan:
- NUM_INPUTS=2, SHIFT=1, tracks +200, +100, pulse wgEn -> done 3 cycles later, outSign=0, outMagnitude=150, clip=0.
- NUM_INPUTS=4, SHIFT=1, tracks +100, -100, +0, -0 -> outSign=0, outMagnitude=0 (no negative zero).
- NUM_INPUTS=4, SHIFT=1, all -255 (sum -1020, scaled 510) -> outSign=1, outMagnitude=255, clip pulse coincident with done.
- SHIFT=1, tracks -3, 0, 0, 0 -> outSign=1, outMagnitude=1 (truncate toward zero). Change inputs to +50 at E0+1 -> result unchanged.
- wgEn pulsed again 2 cycles after the first -> no restart, result from the first snapshot, overrun=1 until reset. Assert reset at E0+2 -> outputs 0, no done, IDLE. Next wgEn mixes normally.
- MIXER_MUTE_EN defined: tracks +80, +80, +80, +80, muteMask=4'b0101, SHIFT=0 -> outMagnitude=160, outSign=0.
